// File: rtl/shift_sequencer.sv
// Multi-cycle variable shifter (SLL/SRL/SRA/ROTR) for the CPU datapath.
// Iterates a shift-by-2 step, with one final shift-by-1 for odd amounts.
module shift_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_d;
  logic [WIDTH-1:0]   step_c;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [1:0]         op_q, op_d;

  // One shift step: by 1 when only one position remains, else by 2
  always_comb begin
    step_c = result_o;
    if (count_q == SHAMT_W'(1)) begin
      case (op_q)
        OP_SLL:  step_c = {result_o[WIDTH-2:0], 1'b0};
        OP_SRL:  step_c = {1'b0, result_o[WIDTH-1:1]};
        OP_SRA:  step_c = {result_o[WIDTH-1], result_o[WIDTH-1:1]};
        OP_ROTR: step_c = {result_o[0], result_o[WIDTH-1:1]};
        default: step_c = result_o;
      endcase
    end else begin
      case (op_q)
        OP_SLL:  step_c = {result_o[WIDTH-3:0], 2'b00};
        OP_SRL:  step_c = {2'b00, result_o[WIDTH-1:2]};
        OP_SRA:  step_c = {{2{result_o[WIDTH-1]}}, result_o[WIDTH-1:2]};
        OP_ROTR: step_c = {result_o[1:0], result_o[WIDTH-1:2]};
        default: step_c = result_o;
      endcase
    end
  end

  // Next-state and datapath update; flush overrides everything but reset
  always_comb begin
    state_d = state_q;
    work_d  = result_o;
    count_d = count_q;
    op_d    = op_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start_i) begin
            work_d  = data_i;
            op_d    = op_i;
            count_d = shamt_i;
            state_d = (shamt_i == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          work_d  = step_c;
          count_d = (count_q >= SHAMT_W'(2)) ? (count_q - SHAMT_W'(2)) : '0;
          state_d = (count_d == '0) ? DONE : SHIFT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registers; busy/done are decoded from the next state so they are flops
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      result_o <= '0;
      count_q  <= '0;
      op_q     <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_o <= work_d;
      count_q  <= count_d;
      op_q     <= op_d;
      busy_o   <= (state_d == SHIFT);
      done_o   <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vectors, literal
// expectations, and a per-cycle comparison against an arithmetic model.
module tb_shift_sequencer;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;

  logic               clk_i;
  logic               rst_i;
  logic               start_i;
  logic [1:0]         op_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic [WIDTH-1:0]   data_i;
  logic               flush_i;
  logic               busy_o;
  logic               done_o;
  logic [WIDTH-1:0]   result_o;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .shamt_i (shamt_i),
    .data_i  (data_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Full shift of d by a positions, computed directly from the operation
  function automatic logic [31:0] shf(input logic [1:0] op, input logic [31:0] d, input int a);
    logic [31:0] r;
    case (op)
      2'b00:   r = d << a;
      2'b01:   r = d >> a;
      2'b10:   r = 32'($signed(d) >>> a);
      default: r = (a == 0) ? d : ((d >> a) | (d << (32 - a)));
    endcase
    return r;
  endfunction

  // Model: positions applied so far grows by 2 per busy cycle up to n
  logic        m_busy, m_done;
  logic [31:0] m_data;
  logic [1:0]  m_op;
  int          m_n, m_app;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_data <= '0; m_op <= '0; m_n <= 0; m_app <= 0;
    end else if (flush_i) begin
      m_busy <= 1'b0; m_done <= 1'b0;
    end else if (!m_busy && start_i) begin
      m_data <= data_i; m_op <= op_i; m_n <= int'(shamt_i); m_app <= 0;
      m_busy <= (shamt_i != 0);
      m_done <= (shamt_i == 0);
    end else if (m_busy) begin
      m_app  <= (m_app + 2 > m_n) ? m_n : m_app + 2;
      m_busy <= (m_app + 2 < m_n);
      m_done <= (m_app + 2 >= m_n);
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk_i) begin
    chk("model_busy",   32'(busy_o),  32'(m_busy));
    chk("model_done",   32'(done_o),  32'(m_done));
    chk("model_result", result_o,     shf(m_op, m_data, m_app));
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] n,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    lat = 0;
    op_i = op; data_i = d; shamt_i = n; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (done_o) begin lat = c; break; end
      @(posedge clk_i); #1;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result",  result_o, exp_res);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int cnt;
    rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; shamt_i = '0; data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_result", result_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Reset in the middle of a long SRL
    op_i = 2'b01; data_i = 32'hFFFF_FFFF; shamt_i = 5'd20; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("midrst_result", result_o, 32'h0);
    chk("midrst_busy", 32'(busy_o), 32'h0);
    chk("midrst_done", 32'(done_o), 32'h0);
    @(posedge clk_i); #1 rst_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (done_o) cnt++;
    end
    chk("midrst_no_done", 32'(cnt), 32'h0);
    @(posedge clk_i); #1;

    run_op(2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004, 2);
    run_op(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 17);
    run_op(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 17);
    run_op(2'b10, 32'h7000_0000, 5'd5,  32'h0380_0000, 4);
    run_op(2'b01, 32'h8000_0000, 5'd3,  32'h1000_0000, 3);
    run_op(2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
    run_op(2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 2);
    run_op(2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456, 5);
    run_op(2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 3);

    // Back-to-back accept in the DONE cycle, plus a start ignored in SHIFT
    op_i = 2'b00; data_i = 32'h1; shamt_i = 5'd4; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("b2b_done1", 32'(done_o), 32'h1);
    chk("b2b_res1", result_o, 32'h0000_0010);
    op_i = 2'b01; data_i = 32'h100; shamt_i = 5'd4; start_i = 1'b1;
    @(posedge clk_i); #1;
    chk("b2b_busy", 32'(busy_o), 32'h1);
    op_i = 2'b00; data_i = 32'hAAAA_5555; shamt_i = 5'd0; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    @(posedge clk_i); #1;
    chk("b2b_done2", 32'(done_o), 32'h1);
    chk("b2b_res2", result_o, 32'h0000_0010);
    @(posedge clk_i); #1;

    // Flush mid-shift holds the intermediate value
    op_i = 2'b00; data_i = 32'h1; shamt_i = 5'd9; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    chk("flush_busy", 32'(busy_o), 32'h0);
    chk("flush_done", 32'(done_o), 32'h0);
    chk("flush_res", result_o, 32'h0000_0010);
    repeat (4) @(posedge clk_i);
    #1;
    chk("flush_hold", result_o, 32'h0000_0010);

    // Flush wins over a simultaneous start
    op_i = 2'b00; data_i = 32'hAAAA_AAAA; shamt_i = 5'd3; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", 32'(busy_o), 32'h0);
    chk("flush_start_res", result_o, 32'h0000_0010);
    repeat (3) @(posedge clk_i);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
